// File: rtl/syzygy_dac_tx_gearbox.sv
`default_nettype none
// ============================================================================
// Module   : syzygy_dac_tx_gearbox
// Purpose  : SYZYGY transmit gearbox. It has a 4-entry sample FIFO, nibble
//            lane mapping, forwarded-clock generation and a training FSM.
// Revision : 1.0 - initial release
// ============================================================================
module syzygy_dac_tx_gearbox #(
  parameter logic [15:0] TRAIN_WORD   = 16'hA55A,
  parameter logic [15:0] IDLE_WORD    = 16'h0000,
  parameter int unsigned TRAIN_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        train_req,
  input  logic [15:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [15:0] tx_data,
  output logic [3:0]  tx_dco,
  output logic        training,
  output logic [2:0]  fifo_level,
  output logic [15:0] underflow_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [15:0] C_TRAIN_LOAD = 16'(TRAIN_CYCLES - 1);
  localparam logic [3:0]  C_DCO_RUN    = 4'b1010;

  // Each nibble is serialized MSB first, so its bit order is reversed.
  function automatic logic [15:0] lane_map(input logic [15:0] word);
    logic [15:0] mapped;
    mapped = '0;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        mapped[4*k+j] = word[4*k+3-j];
      end
    end
    return mapped;
  endfunction

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  level_q, level_d;
  logic        armed_q, armed_d;
  logic [15:0] uflow_q, uflow_d;
  logic [15:0] tx_data_q, tx_data_d;
  logic [3:0]  tx_dco_q, tx_dco_d;
  logic        training_q, training_d;
  logic [15:0] fifo_mem_q [4];
  logic        push, pop;

  assign s_ready         = (state_q != ST_IDLE) && (level_q != 3'd4);
  assign tx_data         = tx_data_q;
  assign tx_dco          = tx_dco_q;
  assign training        = training_q;
  assign fifo_level      = level_q;
  assign underflow_count = uflow_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    armed_d    = armed_q;
    uflow_d    = uflow_q;
    tx_data_d  = lane_map(IDLE_WORD);
    tx_dco_d   = 4'b0000;
    training_d = 1'b0;
    push       = s_valid && s_ready;
    pop        = 1'b0;

    if (!enable) begin
      state_d  = ST_IDLE;
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      level_d  = 3'd0;
      armed_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_TRAIN;
          cnt_d   = C_TRAIN_LOAD;
        end
        ST_TRAIN: begin
          if (train_req) begin
            cnt_d = C_TRAIN_LOAD;
          end else if (cnt_q == 16'd0) begin
            state_d = ST_RUN;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_RUN: begin
          if (train_req) begin
            state_d = ST_TRAIN;
            cnt_d   = C_TRAIN_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Outputs are registered, so they follow the state being entered.
      if (state_d == ST_TRAIN) begin
        tx_data_d  = lane_map(TRAIN_WORD);
        tx_dco_d   = C_DCO_RUN;
        training_d = 1'b1;
        armed_d    = 1'b0;
      end else if (state_d == ST_RUN) begin
        tx_dco_d = C_DCO_RUN;
        if (level_q != 3'd0) begin
          pop       = 1'b1;
          tx_data_d = lane_map(fifo_mem_q[rd_ptr_q]);
          armed_d   = 1'b1;
        end else if (armed_q && (uflow_q != 16'hFFFF)) begin
          uflow_d = uflow_q + 16'd1;
        end
      end

      if (push) wr_ptr_d = wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_d = rd_ptr_q + 2'd1;
      case ({push, pop})
        2'b10:   level_d = level_q + 3'd1;
        2'b01:   level_d = level_q - 3'd1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 16'd0;
      wr_ptr_q   <= 2'd0;
      rd_ptr_q   <= 2'd0;
      level_q    <= 3'd0;
      armed_q    <= 1'b0;
      uflow_q    <= 16'd0;
      tx_data_q  <= 16'd0;
      tx_dco_q   <= 4'b0000;
      training_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      armed_q    <= armed_d;
      uflow_q    <= uflow_d;
      tx_data_q  <= tx_data_d;
      tx_dco_q   <= tx_dco_d;
      training_q <= training_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (push && enable) begin
      fifo_mem_q[wr_ptr_q] <= s_data;
    end
  end

endmodule
`default_nettype wire
